// File: rtl/dm_bus_bridge.sv
// rtl/dm_bus_bridge.sv - CPU data-memory port to single-word bus bridge with lane steering and timeout
module dm_bus_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [2:0]  dmop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        acc_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  wait_cnt;
    logic [31:0] cap_data;
    logic        to_err;
    logic [2:0]  op_q;
    logic [1:0]  lo_q;

    logic        active, faulted, timed_out;
    logic [3:0]  be_nx;
    logic [31:0] wd_nx, load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign active    = dm_read | dm_write;
    assign timed_out = (wait_cnt == LAST_WAIT) && !mem_ack;

    always_comb begin
        faulted = 1'b0;
        case (dmop)
            3'b011, 3'b110, 3'b111: faulted = 1'b1;
            3'b001, 3'b101:         faulted = addr[0];
            3'b010:                 faulted = (addr[1:0] != 2'b00);
            default:                faulted = 1'b0;
        endcase
    end

    // Bus lanes are steered from the request; only legal encodings reach the bus.
    always_comb begin
        be_nx = 4'b1111;
        wd_nx = wdata;
        case (dmop[1:0])
            2'b00: begin
                be_nx = 4'b0001 << addr[1:0];
                wd_nx = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_nx = 4'b0011 << addr[1:0];
                wd_nx = {2{wdata[15:0]}};
            end
            default: begin
                be_nx = 4'b1111;
                wd_nx = wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte  = mem_rdata[{lo_q, 3'b000} +: 8];
        ld_half  = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val = mem_rdata;
        case (op_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {24'h0, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_val = {16'h0, ld_half};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        acc_err  = 1'b0;
        rdata    = 32'h0;
        case (state)
            IDLE: begin
                if (active) begin
                    if (faulted) begin
                        acc_err = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack || timed_out) state_nx = DONE;
            end
            DONE: begin
                rdata    = cap_data;
                acc_err  = to_err;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset must silence the CPU-facing strobes even while request inputs are active.
        if (rst) begin
            stall   = 1'b0;
            acc_err = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            cap_data  <= '0;
            to_err    <= 1'b0;
            op_q      <= '0;
            lo_q      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (active && !faulted) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_write;
                        mem_addr  <= addr[31:2];
                        mem_be    <= be_nx;
                        mem_wdata <= wd_nx;
                        op_q      <= dmop;
                        lo_q      <= addr[1:0];
                        wait_cnt  <= '0;
                        to_err    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        cap_data <= mem_we ? 32'h0 : load_val;
                        wait_cnt <= '0;
                        to_err   <= 1'b0;
                    end else if (timed_out) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        cap_data <= 32'h0;
                        wait_cnt <= '0;
                        to_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: to_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// tb/tb_dm_bus_bridge.sv - directed self-checking bench for dm_bus_bridge
module tb_dm_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_read, dm_write;
    logic [2:0]  dmop;
    logic [31:0] addr, wdata, rdata;
    logic        stall, acc_err;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_mis = 0;

    int          n_stall, n_busy, n_err, n_req, n_we;
    logic        got;
    logic [3:0]  o_be;
    logic        o_we;
    logic [29:0] o_addr;
    logic [31:0] o_wd, o_rdata;

    dm_bus_bridge #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .dm_read(dm_read), .dm_write(dm_write), .dmop(dmop),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .acc_err(acc_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got_v, exp_v);
        end
    endtask

    // Entered and left on a falling edge with the bridge in IDLE; ack_at=0 never acks.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                             input int ack_at, input logic stray);
        dm_read = rd; dm_write = wr; dmop = op; addr = a; wdata = wd; mem_rdata = md;
        n_stall = 0; n_busy = 0; n_err = 0; n_req = 0; n_we = 0; got = 1'b0;
        o_be = '0; o_we = 1'b0; o_addr = '0; o_wd = '0; o_rdata = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (acc_err) n_err++;
            if (mem_req) begin
                if (n_req == 0) begin
                    o_be = mem_be; o_we = mem_we; o_addr = mem_addr; o_wd = mem_wdata;
                end
                n_req++;
                if (mem_we) n_we++;
            end
            if (!stall) begin
                got = 1'b1;
                o_rdata = rdata;
                mem_ack = stray;
            end else begin
                n_stall++;
                if (mem_req) begin
                    n_busy++;
                    mem_ack = (n_busy == ack_at);
                end
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        dm_read = 1'b0; dm_write = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("completed", {31'h0, got}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; dm_read = 1'b1; dm_write = 1'b0; dmop = 3'b010; addr = '0;
        wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        #3;
        check_eq("rst_stall", {31'h0, stall}, 32'h0);
        check_eq("rst_err", {31'h0, acc_err}, 32'h0);
        check_eq("rst_req", {31'h0, mem_req}, 32'h0);
        check_eq("rst_be", {28'h0, mem_be}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        dm_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // LB at 0x103: lane 3 = 0x80, sign-extended
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 1, 1'b0);
        check_eq("lb_stall_cycles", n_stall, 2);
        check_eq("lb_busy", n_busy, 1);
        check_eq("lb_be", {28'h0, o_be}, 32'h8);
        check_eq("lb_addr", {2'b0, o_addr}, 32'h40);
        check_eq("lb_we", {31'h0, o_we}, 32'h0);
        check_eq("lb_rdata", o_rdata, 32'hFFFFFF80);
        check_eq("lb_err", n_err, 0);

        // SH at 0x42, ack on second BUSY cycle
        do_access(1'b0, 1'b1, 3'b001, 32'h42, 32'h0000BEEF, 32'h0, 2, 1'b0);
        check_eq("sh_addr", {2'b0, o_addr}, 32'h10);
        check_eq("sh_be", {28'h0, o_be}, 32'hC);
        check_eq("sh_wdata", o_wd, 32'hBEEFBEEF);
        check_eq("sh_we_cycles", n_we, 2);
        check_eq("sh_busy", n_busy, 2);
        check_eq("sh_rdata", o_rdata, 32'h0);

        // SB at 0x5
        do_access(1'b0, 1'b1, 3'b000, 32'h5, 32'h000000A5, 32'h0, 1, 1'b0);
        check_eq("sb_addr", {2'b0, o_addr}, 32'h1);
        check_eq("sb_be", {28'h0, o_be}, 32'h2);
        check_eq("sb_wdata", o_wd, 32'hA5A5A5A5);

        // LH at 0x2: upper half 0x8001 sign-extended
        do_access(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h80011234, 1, 1'b0);
        check_eq("lh_be", {28'h0, o_be}, 32'hC);
        check_eq("lh_rdata", o_rdata, 32'hFFFF8001);

        // Misaligned LW
        do_access(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1, 1'b0);
        check_eq("lw_mis_err", n_err, 1);
        check_eq("lw_mis_stall", n_stall, 0);
        check_eq("lw_mis_req", n_req, 0);
        check_eq("lw_mis_rdata", o_rdata, 32'h0);

        // Misaligned LH and illegal funct3
        do_access(1'b1, 1'b0, 3'b001, 32'h3, 32'h0, 32'h0, 1, 1'b0);
        check_eq("lh_mis_err", n_err, 1);
        check_eq("lh_mis_req", n_req, 0);
        do_access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 1'b0);
        check_eq("op011_err", n_err, 1);
        check_eq("op011_stall", n_stall, 0);

        // LHU timeout with TIMEOUT=4
        do_access(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 32'hFFFFFFFF, 0, 1'b0);
        check_eq("to_busy", n_busy, 4);
        check_eq("to_stall", n_stall, 5);
        check_eq("to_err", n_err, 1);
        check_eq("to_rdata", o_rdata, 32'h0);

        // Reset asserted mid-cycle during BUSY
        dm_read = 1'b1; dmop = 3'b100; addr = 32'h1;
        @(negedge clk);
        #1;
        check_eq("rb_req_before", {31'h0, mem_req}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check_eq("rb_req", {31'h0, mem_req}, 32'h0);
        check_eq("rb_stall", {31'h0, stall}, 32'h0);
        check_eq("rb_err", {31'h0, acc_err}, 32'h0);
        dm_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_access(1'b1, 1'b0, 3'b100, 32'h1, 32'h0, 32'h0000AB00, 1, 1'b0);
        check_eq("lbu_rdata", o_rdata, 32'h000000AB);
        check_eq("lbu_err", n_err, 0);

        // Read+write together acts as SW; stray ack in DONE
        do_access(1'b1, 1'b1, 3'b010, 32'h8, 32'h12345678, 32'hDEADBEEF, 1, 1'b1);
        check_eq("rw_we", {31'h0, o_we}, 32'h1);
        check_eq("rw_be", {28'h0, o_be}, 32'hF);
        check_eq("rw_wdata", o_wd, 32'h12345678);
        check_eq("rw_addr", {2'b0, o_addr}, 32'h2);
        check_eq("rw_rdata", o_rdata, 32'h0);
        #1;
        check_eq("done_ack_req", {31'h0, mem_req}, 32'h0);
        check_eq("done_ack_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);

        // Stray ack in IDLE
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check_eq("idle_ack_req", {31'h0, mem_req}, 32'h0);
        check_eq("idle_ack_stall", {31'h0, stall}, 32'h0);
        check_eq("idle_ack_rdata", rdata, 32'h0);
        check_eq("idle_ack_err", {31'h0, acc_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dm_bus_bridge.md
DM_BUS_BRIDGE -- requirements
Module: dm_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of cycles to wait for mem_ack; legal range is 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 dm_read  input  1  CPU load request, held stable while stall=1.
REQ-005 dm_write  input  1  CPU store request, held stable while stall=1.
REQ-006 dmop  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data; valid bytes are LSB-aligned.
REQ-009 rdata  output  32  extended load result.
REQ-010 stall  output  1  freezes the CPU PC and register-file write.
REQ-011 acc_err  output  1  one-cycle pulse on a misaligned, illegal or timed-out access.
REQ-012 mem_req  output  1  word-bus request, registered.
REQ-013 mem_we  output  1  word-bus write enable, registered.
REQ-014 mem_addr  output  30  word address (addr[31:2]), registered.
REQ-015 mem_be  output  4  byte enables, registered.
REQ-016 mem_wdata  output  32  lane-replicated store data, registered.
REQ-017 mem_rdata  input  32  word read data, valid when mem_ack=1.
REQ-018 mem_ack  input  1  single-cycle completion strobe.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-020 An access is active when dm_read or dm_write is 1; if both are 1, it SHALL be treated as a write.
REQ-021 An active access SHALL be faulted if dmop is 011, 110 or 111, or if it is H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-022 In IDLE, an active faulted access SHALL pulse acc_err for one cycle, drive rdata=0 and stall=0, issue no bus cycle, and leave the state at IDLE.
REQ-023 In IDLE, an active legal access SHALL set stall=1 combinationally and move to BUSY, registering mem_req=1, mem_we, mem_addr, mem_be and mem_wdata.
REQ-024 mem_be SHALL be 0001<<addr[1:0] for B, 0011<<addr[1:0] for H, and 1111 for W.
REQ-025 mem_wdata SHALL be wdata[7:0] replicated four times for B, wdata[15:0] twice for H, and wdata for W.
REQ-026 In BUSY, stall SHALL be 1 and mem_req and the other bus outputs SHALL be held unchanged until mem_ack=1.
REQ-027 On mem_ack=1 in BUSY, the block SHALL clear mem_req and mem_we, capture the load data, reset the wait counter, and move to DONE.
REQ-028 The load result SHALL select its lane by addr[1:0] (byte) or addr[1] (half), then sign-extend for B/H and zero-extend for BU/HU; stores SHALL capture 0.
REQ-029 An 8-bit wait counter SHALL count BUSY cycles.
REQ-030 If the counter reaches TIMEOUT-1 without mem_ack, the block SHALL clear mem_req, capture 0, pulse acc_err and move to DONE.
REQ-031 In DONE, stall SHALL be 0 and rdata SHALL equal the captured value for exactly one cycle, after which the state SHALL return to IDLE unconditionally.
REQ-032 In DONE, the request inputs SHALL be ignored, so no second access is issued for the same instruction.
REQ-033 mem_ack SHALL be ignored in IDLE and DONE.
REQ-034 Minimum legal-access latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE); stall is high for 2 cycles.
REQ-035 If no access is active in IDLE, stall SHALL be 0 and rdata SHALL be 0.

Reset
REQ-036 While rst=1, the block SHALL be in IDLE with all registered outputs, the counter and the captured data at 0, and stall=0 and acc_err=0 immediately, regardless of clk.
REQ-037 Reset asserted in BUSY SHALL drop mem_req asynchronously and abandon the access without acc_err.
REQ-038 After rst deasserts, the first rising edge of clk SHALL evaluate the inputs from IDLE.

Verification
REQ-039 LB: addr=0x00000103, mem_rdata=0x80FF7F01, ack on the 1st BUSY cycle -> mem_be=1000, stall high for 2 cycles, rdata=0xFFFFFF80 in DONE.
REQ-040 SH: addr=0x00000042, wdata=0x0000BEEF -> mem_addr=0x10, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_we=1 until ack.
REQ-041 LW: addr=0x00000006 -> acc_err=1 for 1 cycle, stall=0, mem_req never asserted.
REQ-042 TIMEOUT=4, LHU, no ack -> exactly 4 BUSY cycles, then acc_err pulse, rdata=0, return to IDLE.
REQ-043 rst asserted mid-clock during BUSY -> mem_req=0 and stall=0 before the next edge; a later LBU at addr 0x1, mem_rdata=0x0000AB00 -> rdata=0x000000AB.
REQ-044 dm_read=dm_write=1, dmop=010 -> a write bus cycle with mem_be=1111, and a stray mem_ack in IDLE and DONE has no effect.
